// File: rtl/fetch_queue.sv
// Dual-lane instruction queue between fetch and issue: accepts up to two
// instructions per cycle, tags them with non-zero IDs, presents the oldest two.
module fetch_queue #(
  parameter int unsigned DEPTH                = 8,
  parameter int unsigned INST_WIDTH           = 32,
  parameter int unsigned ADDR_WIDTH           = 32,
  parameter int unsigned INSTRUCTION_ID_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [1:0]                      push_vld,
  input  logic [INST_WIDTH-1:0]           instruction0_in,
  input  logic [INST_WIDTH-1:0]           instruction1_in,
  input  logic [ADDR_WIDTH-1:0]           pc0_in,
  input  logic [ADDR_WIDTH-1:0]           pc1_in,
  output logic                            full,
  input  logic                            stall,
  output logic [INST_WIDTH-1:0]           instruction0_out,
  output logic [INST_WIDTH-1:0]           instruction1_out,
  output logic [ADDR_WIDTH-1:0]           pc0_out,
  output logic [ADDR_WIDTH-1:0]           pc1_out,
  output logic [INSTRUCTION_ID_WIDTH-1:0] id0_out,
  output logic [INSTRUCTION_ID_WIDTH-1:0] id1_out,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = INSTRUCTION_ID_WIDTH;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic [IW-1:0]         id;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] next_id_q, next_id_d;
  logic [IW-1:0] id_lane0, id_lane1;
  logic          overflow_q, overflow_d;
  logic          push_ok, push_two, bad_push;
  logic [1:0]    n_push, n_pop;
  entry_t        wr0, wr1, rd0, rd1;

  // ID 0 marks a bubble downstream, so the counter wraps from max to 1.
  function automatic logic [IW-1:0] id_inc(input logic [IW-1:0] id);
    logic [IW-1:0] nxt;
    nxt = id + IW'(1);
    if (nxt == '0) nxt = IW'(1);
    return nxt;
  endfunction

  assign full     = (count_q >= CW'(DEPTH - 1));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign head_p1  = head_q + PW'(1);
  assign tail_p1  = tail_q + PW'(1);
  assign id_lane0 = next_id_q;
  assign id_lane1 = id_inc(next_id_q);

  assign wr0 = '{inst: instruction0_in, pc: pc0_in, id: id_lane0};
  assign wr1 = '{inst: instruction1_in, pc: pc1_in, id: id_lane1};

  // Push/pop accounting and next-state for pointers, count, ID and overflow.
  always_comb begin
    push_ok    = 1'b0;
    push_two   = 1'b0;
    bad_push   = 1'b0;
    n_push     = 2'd0;
    n_pop      = 2'd0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    next_id_d  = next_id_q;
    overflow_d = overflow_q;

    push_ok  = !full && (push_vld == 2'b01 || push_vld == 2'b11);
    push_two = push_ok && push_vld[1];
    bad_push = (push_vld != 2'b00) && (full || push_vld == 2'b10);
    n_push   = push_two ? 2'd2 : (push_ok ? 2'd1 : 2'd0);
    n_pop    = stall ? 2'd0 : ((count_q >= CW'(2)) ? 2'd2 : 2'(count_q));

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d     = head_q + PW'(n_pop);
      tail_d     = tail_q + PW'(n_push);
      count_d    = count_q + CW'(n_push) - CW'(n_pop);
      overflow_d = overflow_q | bad_push;
      if (push_two)     next_id_d = id_inc(id_lane1);
      else if (push_ok) next_id_d = id_lane1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      next_id_q  <= IW'(1);
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      next_id_q  <= next_id_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are don't-care until covered by count.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) begin
      mem_q[tail_q] <= wr0;
      if (push_two) mem_q[tail_p1] <= wr1;
    end
  end

  assign rd0 = (count_q != '0)        ? mem_q[head_q]  : '0;
  assign rd1 = (count_q >= CW'(2))    ? mem_q[head_p1] : '0;

  assign instruction0_out = rd0.inst;
  assign pc0_out          = rd0.pc;
  assign id0_out          = rd0.id;
  assign instruction1_out = rd1.inst;
  assign pc1_out          = rd1.pc;
  assign id1_out          = rd1.id;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference FIFO model predicts outputs,
// occupancy, full and overflow every cycle.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned INSTW = 32;
  localparam int unsigned ADDRW = 32;
  localparam int unsigned IDW   = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTW-1:0] inst;
    logic [ADDRW-1:0] pc;
    logic [IDW-1:0]   id;
  } entry_t;

  logic             clk = 1'b0;
  logic             reset, flush, stall;
  logic [1:0]       push_vld;
  logic [INSTW-1:0] instruction0_in, instruction1_in;
  logic [ADDRW-1:0] pc0_in, pc1_in;
  logic             full, overflow;
  logic [INSTW-1:0] instruction0_out, instruction1_out;
  logic [ADDRW-1:0] pc0_out, pc1_out;
  logic [IDW-1:0]   id0_out, id1_out;
  logic [CW-1:0]    count;

  fetch_queue #(
    .DEPTH(DEPTH), .INST_WIDTH(INSTW), .ADDR_WIDTH(ADDRW), .INSTRUCTION_ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .push_vld(push_vld),
    .instruction0_in(instruction0_in), .instruction1_in(instruction1_in),
    .pc0_in(pc0_in), .pc1_in(pc1_in), .full(full), .stall(stall),
    .instruction0_out(instruction0_out), .instruction1_out(instruction1_out),
    .pc0_out(pc0_out), .pc1_out(pc1_out), .id0_out(id0_out), .id1_out(id1_out),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned    n_checks = 0;
  int unsigned    n_pass   = 0;
  entry_t         sb[$];
  logic [IDW-1:0] m_id;
  logic           m_ovf;
  logic [ADDRW-1:0] pc_ctr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [IDW-1:0] model_next_id(input logic [IDW-1:0] id);
    return (id == {IDW{1'b1}}) ? IDW'(1) : id + IDW'(1);
  endfunction

  task automatic compare_outputs();
    entry_t e0, e1;
    e0 = (sb.size() >= 1) ? sb[0] : '0;
    e1 = (sb.size() >= 2) ? sb[1] : '0;
    check("count",    64'(count),    64'(sb.size()));
    check("full",     64'(full),     64'(sb.size() >= DEPTH - 1));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("inst0",    64'(instruction0_out), 64'(e0.inst));
    check("pc0",      64'(pc0_out),  64'(e0.pc));
    check("id0",      64'(id0_out),  64'(e0.id));
    check("inst1",    64'(instruction1_out), 64'(e1.inst));
    check("pc1",      64'(pc1_out),  64'(e1.pc));
    check("id1",      64'(id1_out),  64'(e1.id));
  endtask

  // One clock: check current outputs, drive stimulus, advance the model.
  task automatic step(input logic [1:0] pv, input logic st, input logic fl);
    entry_t e0, e1;
    int     npop;
    bit     full_m;
    compare_outputs();
    e0.inst = $urandom; e0.pc = pc_ctr;          e0.id = '0;
    e1.inst = $urandom; e1.pc = pc_ctr + ADDRW'(4); e1.id = '0;
    pc_ctr  = pc_ctr + ADDRW'(8);
    push_vld = pv; stall = st; flush = fl;
    instruction0_in = e0.inst; pc0_in = e0.pc;
    instruction1_in = e1.inst; pc1_in = e1.pc;
    if (fl) begin
      sb.delete();
    end else begin
      full_m = (sb.size() >= DEPTH - 1);
      npop   = st ? 0 : ((sb.size() >= 2) ? 2 : sb.size());
      if (pv != 2'b00 && (full_m || pv == 2'b10)) m_ovf = 1'b1;
      for (int i = 0; i < npop; i++) void'(sb.pop_front());
      if (!full_m && (pv == 2'b01 || pv == 2'b11)) begin
        e0.id = m_id; m_id = model_next_id(m_id); sb.push_back(e0);
        if (pv == 2'b11) begin
          e1.id = m_id; m_id = model_next_id(m_id); sb.push_back(e1);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; stall = 1'b0; push_vld = 2'b00;
    instruction0_in = '0; instruction1_in = '0; pc0_in = '0; pc1_in = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete(); m_id = IDW'(1); m_ovf = 1'b0;
  endtask

  initial begin
    int r;
    logic [1:0] pv;
    pc_ctr = ADDRW'('h10);
    do_reset();
    do_reset();

    // Pair in, out next cycle, then empty.
    step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // Single into empty queue, then pop.
    step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // Fill under stall to count=7, overflow attempts, then drain in order.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(2'b00, 1'b0, 1'b0);

    // Reset clears overflow; fill then flush while pushing.
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0);
    step(2'b11, 1'b0, 1'b1);
    step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // Illegal lane pattern with space available.
    step(2'b10, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // ID wraparound: more pushes than the ID space.
    do_reset();
    for (int i = 0; i < 12; i++) step(2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  step(2'b01, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);

    // Mixed push/stall traffic across pointer wrap.
    do_reset();
    for (int i = 0; i < 6 * DEPTH; i++) begin
      r = $urandom_range(0, 9);
      pv = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'b11;
      if (sb.size() >= DEPTH - 1) pv = 2'b00;
      step(pv, 1'($urandom_range(0, 2) == 0), 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) step(2'b00, 1'b0, 1'b0);
    compare_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
